// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//
// Registered RISC-V instruction-decode stage between fetch and issue.
// It accepts one 32-bit instruction and its PC per valid/ready handshake. It
// splits the instruction into register indices, function codes, a
// sign-extended immediate and a format tag, and flags undecodable encodings.
// The output is a single-entry buffer that sustains one bundle per cycle.
//
// Parameters
//   XLEN      : 32 or 64. Sets the pc/imm width. W-opcodes are legal only at 64.
//   RVC_CHECK : when 1, an instruction with [1:0] != 2'b11 is flagged illegal.
//
// Ports
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   flush               : drops the held bundle and any concurrent transfer
//   in_valid / in_ready : upstream handshake (in_ready = !out_valid || out_ready)
//   in_instr, in_pc     : raw instruction and its address
//   out_valid/out_ready : downstream handshake
//   out_pc, out_opcode  : captured pc and instruction[6:0]
//   out_rd/rs1/rs2      : register indices, 0 when the format has no such field
//   out_funct3/funct7   : function codes, 0 when unused
//   out_imm             : sign-extended immediate, 0 for R-type
//   out_format          : R=0 I=1 S=2 B=3 U=4 J=5 invalid=7
//   out_illegal         : instruction not decodable
//
// Optional feature (macro DECODE_STAGE_PERF_EN)
//   perf_decoded, perf_illegal : 32-bit wrapping counters of output handshakes
//   and of illegal bundles handed downstream. Flushed bundles are not counted.
// -----------------------------------------------------------------------------
module decode_stage #(
  parameter int XLEN      = 64,
  parameter bit RVC_CHECK = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_format,
  output logic            out_illegal
`ifdef DECODE_STAGE_PERF_EN
  ,
  output logic [31:0]     perf_decoded,
  output logic [31:0]     perf_illegal
`endif
);

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_INV = 3'd7
  } fmt_e;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [6:0]      r_opcode;
  logic [4:0]      r_rd;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [2:0]      r_funct3;
  logic [6:0]      r_funct7;
  logic [XLEN-1:0] r_imm;
  fmt_e            r_format;
  logic            r_illegal;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic w_xfer;

  // The buffer can take a new bundle when it is empty or is being drained
  // this cycle. Flush deliberately does not gate in_ready; it only blocks the
  // register update.
  assign in_ready = !r_valid || out_ready;
  assign w_xfer   = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Immediates, built at 32 bits and sign-extended to XLEN afterwards
  // ---------------------------------------------------------------------------
  logic [6:0]         w_opcode;
  logic signed [31:0] w_imm_i;
  logic signed [31:0] w_imm_s;
  logic signed [31:0] w_imm_b;
  logic signed [31:0] w_imm_u;
  logic signed [31:0] w_imm_j;

  assign w_opcode = in_instr[6:0];
  assign w_imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign w_imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign w_imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                     in_instr[30:25], in_instr[11:8], 1'b0};
  assign w_imm_u  = {in_instr[31:12], 12'b0};
  assign w_imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                     in_instr[20], in_instr[30:21], 1'b0};

  // ---------------------------------------------------------------------------
  // Opcode classification
  // ---------------------------------------------------------------------------
  fmt_e w_fmt_raw;
  logic w_op_known;
  logic w_illegal;
  fmt_e w_fmt;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    w_fmt_raw  = FMT_INV;
    w_op_known = 1'b1;
    case (w_opcode)
      OPC_OP:                                     w_fmt_raw = FMT_R;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR,
      OPC_MISC_MEM, OPC_SYSTEM:                   w_fmt_raw = FMT_I;
      OPC_STORE:                                  w_fmt_raw = FMT_S;
      OPC_BRANCH:                                 w_fmt_raw = FMT_B;
      OPC_LUI, OPC_AUIPC:                         w_fmt_raw = FMT_U;
      OPC_JAL:                                    w_fmt_raw = FMT_J;
      // W-opcodes only exist on RV64.
      OPC_OP_IMM_32: begin
        if (XLEN == 64) w_fmt_raw  = FMT_I;
        else            w_op_known = 1'b0;
      end
      OPC_OP_32: begin
        if (XLEN == 64) w_fmt_raw  = FMT_R;
        else            w_op_known = 1'b0;
      end
      default:                                    w_op_known = 1'b0;
    endcase
  end

  assign w_illegal = !w_op_known || (RVC_CHECK && (in_instr[1:0] != 2'b11));
  assign w_fmt     = w_illegal ? FMT_INV : w_fmt_raw;

  // ---------------------------------------------------------------------------
  // Field extraction: only fields the format actually carries are passed on,
  // everything else (including all fields of an illegal instruction) is zero.
  // ---------------------------------------------------------------------------
  logic [4:0]         w_rd;
  logic [4:0]         w_rs1;
  logic [4:0]         w_rs2;
  logic [2:0]         w_funct3;
  logic [6:0]         w_funct7;
  logic signed [31:0] w_imm32;
  logic [XLEN-1:0]    w_imm;

  always_comb begin
    w_rd     = '0;
    w_rs1    = '0;
    w_rs2    = '0;
    w_funct3 = '0;
    w_funct7 = '0;
    w_imm32  = '0;
    case (w_fmt)
      FMT_R: begin
        w_rd     = in_instr[11:7];
        w_rs1    = in_instr[19:15];
        w_rs2    = in_instr[24:20];
        w_funct3 = in_instr[14:12];
        w_funct7 = in_instr[31:25];
      end
      FMT_I: begin
        w_rd     = in_instr[11:7];
        w_rs1    = in_instr[19:15];
        w_funct3 = in_instr[14:12];
        w_imm32  = w_imm_i;
        // OP-IMM-32 shifts carry a funct7 that issue needs to tell SRAIW/SRLIW.
        if (w_opcode == OPC_OP_IMM_32) w_funct7 = in_instr[31:25];
      end
      FMT_S: begin
        w_rs1    = in_instr[19:15];
        w_rs2    = in_instr[24:20];
        w_funct3 = in_instr[14:12];
        w_imm32  = w_imm_s;
      end
      FMT_B: begin
        w_rs1    = in_instr[19:15];
        w_rs2    = in_instr[24:20];
        w_funct3 = in_instr[14:12];
        w_imm32  = w_imm_b;
      end
      FMT_U: begin
        w_rd    = in_instr[11:7];
        w_imm32 = w_imm_u;
      end
      FMT_J: begin
        w_rd    = in_instr[11:7];
        w_imm32 = w_imm_j;
      end
      default: ;
    endcase
  end

  // Signed source, so the width cast sign-extends on RV64.
  assign w_imm = XLEN'(w_imm32);

  // ---------------------------------------------------------------------------
  // Output buffer. Priority: reset, flush, load on transfer, drain on pop.
  // A pop without a push only clears valid; the data keeps its stale values.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the data registers are reset as well, because the idle output
    // values (zeros, format 7) are visible to downstream logic.
    if (rst) begin
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_opcode  <= '0;
      r_rd      <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_funct3  <= '0;
      r_funct7  <= '0;
      r_imm     <= '0;
      r_format  <= FMT_INV;
      r_illegal <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_xfer) begin
      // NOTE: non-blocking assignments throughout clocked state, so every
      // register samples the pre-edge values regardless of statement order.
      r_valid   <= 1'b1;
      r_pc      <= in_pc;
      r_opcode  <= w_opcode;
      r_rd      <= w_rd;
      r_rs1     <= w_rs1;
      r_rs2     <= w_rs2;
      r_funct3  <= w_funct3;
      r_funct7  <= w_funct7;
      r_imm     <= w_imm;
      r_format  <= w_fmt;
      r_illegal <= w_illegal;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid   = r_valid;
  assign out_pc      = r_pc;
  assign out_opcode  = r_opcode;
  assign out_rd      = r_rd;
  assign out_rs1     = r_rs1;
  assign out_rs2     = r_rs2;
  assign out_funct3  = r_funct3;
  assign out_funct7  = r_funct7;
  assign out_imm     = r_imm;
  assign out_format  = r_format;
  assign out_illegal = r_illegal;

`ifdef DECODE_STAGE_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters: count bundles actually handed downstream.
  // ---------------------------------------------------------------------------
  logic        w_pop;
  logic [31:0] r_perf_decoded;
  logic [31:0] r_perf_illegal;

  assign w_pop = r_valid && out_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_decoded <= '0;
      r_perf_illegal <= '0;
    end else if (w_pop) begin
      r_perf_decoded <= r_perf_decoded + 32'd1;
      if (r_illegal) r_perf_illegal <= r_perf_illegal + 32'd1;
    end
  end

  assign perf_decoded = r_perf_decoded;
  assign perf_illegal = r_perf_illegal;
`endif

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised instruction-decode pipeline stage sitting between fetch and issue/register-read.
- Accepts one 32-bit RISC-V instruction plus its PC per valid/ready handshake and splits out rd/rs1/rs2/funct3/funct7/immediate/format.
- Generalised over XLEN (RV32I/RV64I), adds illegal-instruction detection, FENCE/SYSTEM decoding, flush, and one-entry output buffering with full throughput.

Parameters:
- XLEN, 64, datapath width; legal values 32 or 64; sets imm and pc width and whether W-opcodes are legal.
- RVC_CHECK, 1, when 1, instruction[1:0] != 2'b11 is flagged illegal.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- flush  input  1  drops held and incoming instruction this cycle
- in_valid  input  1  instruction/pc valid
- in_ready  output  1  stage can accept
- in_instr  input  32  raw instruction
- in_pc  input  XLEN  instruction address
- out_valid  output  1  decoded bundle valid
- out_ready  input  1  downstream accepts
- out_pc  output  XLEN  registered pc
- out_opcode  output  7  instruction[6:0]
- out_rd, out_rs1, out_rs2  output  5 each  register indices; 0 when unused by format
- out_funct3  output  3  function code; 0 when unused
- out_funct7  output  7  instruction[31:25] for R-type and OP-IMM-32; else 0
- out_imm  output  XLEN  sign-extended immediate; 0 for R-type
- out_format  output  3  R=0, I=1, S=2, B=3, U=4, J=5, invalid=7
- out_illegal  output  1  instruction not decodable

Behaviour:
- Reset: out_valid=0; all out_* data fields=0; out_format=7. in_ready follows its combinational equation.
- Handshake: in_ready = !out_valid || out_ready, combinational, no dependence on in_valid. Transfer occurs when in_valid && in_ready.
- Latency is 1 cycle: a transfer at edge N presents the bundle at edge N+1. Back-to-back throughput is 1 per cycle when out_ready=1.
- Output registers update only on transfer. When out_valid && !out_ready, all out_* are held stable.
- Pop without push: out_valid falls, data fields keep their stale values.
- Decode (combinational, then registered):
  - OP 0110011 → R
  - OP-IMM 0010011, LOAD 0000011, JALR 1100111, MISC-MEM 0001111, SYSTEM 1110011 → I
  - STORE 0100011 → S
  - BRANCH 1100011 → B
  - LUI 0110111, AUIPC 0010111 → U
  - JAL 1101111 → J
  - OP-IMM-32 0011011 → I; OP-32 0111011 → R. Both legal only when XLEN=64.
- Immediates sign-extend from instruction[31] to XLEN:
  - I = [31:20]
  - S = [31:25,11:7]
  - B = [31,7,30:25,11:8,0]
  - U = [31:12,12'b0]
  - J = [31,19:12,20,30:21,0]
- Illegal conditions, OR-ed:
  - unlisted opcode
  - W-opcode when XLEN=32
  - RVC_CHECK && instr[1:0]!=2'b11
- On illegal: out_illegal=1, out_format=7, rd/rs1/rs2/funct3/funct7/imm=0. out_pc and out_opcode are still captured.
- Flush: next edge sets out_valid=0 and suppresses any concurrent transfer; flush dominates in_valid and out_ready. in_ready is unaffected by flush.
- Reset mid-transfer: out_valid clears immediately (asynchronous); the pending instruction is lost.

Optional Feature:
- Macro DECODE_STAGE_PERF_EN.
- When defined, adds outputs perf_decoded[31:0] and perf_illegal[31:0]. Counters increment on each output handshake (out_valid && out_ready && !flush); perf_illegal increments only when out_illegal=1.
- Counters reset to 0 and wrap modulo 2^32.
- When undefined, the ports and counters are absent; the rest of the behaviour is identical.

Test Plan:
1. XLEN=64, in_instr=0x00500093 (addi x1,x0,5), out_ready=1 → next cycle out_valid=1, rd=1, rs1=0, funct3=0, imm=5, format=1, illegal=0.
2. Back-to-back sequence, out_ready held high:
   - 0x0020A423 (sw x2,8(x1)) → format=2, rs1=1, rs2=2, imm=8
   - 0xFE000EE3 (beq) → format=3, imm=0xFFFF_FFFF_FFFF_FFFC
   - 0x800002B7 (lui x5) → format=4, rd=5, imm=0xFFFF_FFFF_8000_0000
   - three bundles on three consecutive cycles, no bubbles.
3. Backpressure: out_ready=0 for 4 cycles with in_valid=1 → in_ready=0, outputs stable. Release → held bundle pops, next instruction loaded the same edge, no loss or duplication.
4. XLEN=32, in_instr=0x0010009B (addiw) → illegal=1, format=7, imm=0. The same instruction at XLEN=64 gives format=1, imm=1, funct7=0.
5. Flush asserted together with in_valid=1, out_ready=0 → out_valid=0 next cycle, new instruction discarded. Then assert rst mid-stream → out_valid drops asynchronously before the next clock edge.
6. With DECODE_STAGE_PERF_EN defined: 10 accepted instructions including 2 illegal (opcode 0x7F) → perf_decoded=10, perf_illegal=2. Flushed entries are not counted.
